// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : First-word-fall-through FIFO controller driving an external
//               dist_ram, with a one-word registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int DATA_DEPTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [ADDRESS_WIDTH-1:0] ram_in_addr,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    output logic                     ram_write_en,
    output logic [ADDRESS_WIDTH-1:0] ram_out_addr,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam logic [ADDRESS_WIDTH:0]   c_depth     = (ADDRESS_WIDTH+1)'(DATA_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_last_addr = ADDRESS_WIDTH'(DATA_DEPTH - 1);

    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [ADDRESS_WIDTH:0]   r_ram_cnt;
    logic                     r_rd_valid;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic                     w_push;
    logic                     w_load;

    // Wrap at DATA_DEPTH-1 so non-power-of-two depths use every entry.
    function automatic logic [ADDRESS_WIDTH-1:0] next_ptr(input logic [ADDRESS_WIDTH-1:0] ptr);
        return (ptr == c_last_addr) ? '0 : ptr + 1'b1;
    endfunction

    assign full         = (r_ram_cnt == c_depth);
    assign wr_ready     = ~full;
    assign w_push       = wr_valid & wr_ready;
    assign w_load       = (r_ram_cnt != '0) && (!r_rd_valid || rd_ready);

    assign ram_in_addr  = r_wr_ptr;
    assign ram_data_in  = wr_data;
    assign ram_write_en = w_push;
    assign ram_out_addr = r_rd_ptr;

    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign count        = r_ram_cnt + (ADDRESS_WIDTH+1)'(r_rd_valid);
    assign empty        = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end

            // Without a load, a pop can only happen with the RAM empty.
            if (w_load) begin
                r_rd_ptr   <= next_ptr(r_rd_ptr);
                r_rd_data  <= ram_data_out;
                r_rd_valid <= 1'b1;
            end else if (r_rd_valid && rd_ready) begin
                r_rd_valid <= 1'b0;
            end

            case ({w_push, w_load})
                2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
                2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire
